// File: rtl/ram_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Package : ram_pkg
// Purpose : Shared types and helpers for the ram_sweep block.
//           - state_t   : sweep controller states (SWEEP, IDLE)
//           - is_access : true when a user request is presented
// Rev     : 1.0  initial release
// ============================================================================
package ram_pkg;

  // SWEEP is encoded as zero so the reset value reads naturally in a
  // waveform viewer as "not yet usable".
  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // A request counts as an access only when enabled and at least one of
  // read/write is asked for.
  function automatic logic is_access(input logic e, input logic w, input logic r);
    return e & (w | r);
  endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_sweep_if.sv
`default_nettype none
// ============================================================================
// Interface : ram_sweep_if
// Purpose   : User-side access bundle of the ram_sweep block.
// Ports     : e, w, r, addr, din, clr  - requests from the user (master)
//             dout, dvalid, busy, rej  - responses from the RAM (slave)
// Rev       : 1.0  initial release
// ============================================================================
interface ram_sweep_if #(
  parameter int DW = 16,
  parameter int AW = 6
);

  logic          e;
  logic          w;
  logic          r;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          clr;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          busy;
  logic          rej;

  modport master (
    output e, w, r, addr, din, clr,
    input  dout, dvalid, busy, rej
  );

  modport slave (
    input  e, w, r, addr, din, clr,
    output dout, dvalid, busy, rej
  );

endinterface : ram_sweep_if
`default_nettype wire

// File: rtl/ram_sweep_core.sv
`default_nettype none
// ============================================================================
// Module  : ram_core
// Purpose : DW x 2**AW storage array, one synchronous write port and one
//           registered read port sharing a single address.
// Ports   : clk, rst      - clock, async active-high reset (read reg only)
//           we, re        - write / read strobes
//           addr          - shared word address
//           wdata         - write data
//           rdata         - registered read data (resets to 0)
// Rev     : 1.0  initial release
// ============================================================================
module ram_core #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          we,
  input  wire logic          re,
  input  wire logic [AW-1:0] addr,
  input  wire logic [DW-1:0] wdata,
  output      logic [DW-1:0] rdata
);

  localparam int c_DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [0:c_DEPTH-1];
  logic [DW-1:0] r_rdata;

  // The array carries no reset so it maps onto plain RAM primitives; its
  // contents become defined through the clear sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Both ports update on the same edge through non-blocking assignments, so
  // a simultaneous read and write to one address returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule : ram_core
`default_nettype wire

// File: rtl/ram_sweep.sv
`default_nettype none
// ============================================================================
// Module  : ram_sweep
// Purpose : Single-port synchronous RAM with a built-in clear sweep. After
//           reset, and whenever clr is seen in IDLE, every word is written
//           with CLR_VAL, one word per cycle; user accesses arriving during
//           the sweep are rejected with a one-cycle rej pulse.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - ram_sweep_if.slave: e/w/r/addr/din/clr in,
//                  dout/dvalid/busy/rej out
// Rev     : 1.0  initial release
// ============================================================================
module ram_sweep
  import ram_pkg::*;
#(
  parameter int          DW      = 16,
  parameter int          AW      = 6,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input wire logic    clk,
  input wire logic    rst,
  ram_sweep_if.slave  bus
);

  localparam logic [AW-1:0] c_LAST_ADDR = {AW{1'b1}};

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_dvalid;
  logic          r_rej;

  logic          w_sweeping;
  logic          w_access;
  logic          w_core_we;
  logic          w_core_re;
  logic [AW-1:0] w_core_addr;
  logic [DW-1:0] w_core_wdata;
  logic [DW-1:0] w_core_rdata;

  assign w_sweeping = (r_state == SWEEP);
  assign w_access   = is_access(bus.e, bus.w, bus.r);

  // Access mux: the sweep owns the array port completely while it runs;
  // user requests only reach the array in IDLE.
  always_comb begin
    w_core_we    = 1'b0;
    w_core_re    = 1'b0;
    w_core_addr  = bus.addr;
    w_core_wdata = bus.din;
    if (w_sweeping) begin
      w_core_we    = 1'b1;
      w_core_addr  = r_cnt;
      w_core_wdata = CLR_VAL;
    end else begin
      w_core_we = bus.e & bus.w;
      w_core_re = bus.e & bus.r;
    end
  end

  // Sweep controller with its registered strobes. The counter wraps to 0
  // naturally on the edge that writes the last address, so the next clr
  // can also simply force it back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SWEEP;
      r_cnt    <= '0;
      r_dvalid <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      r_rej    <= 1'b0;
      case (r_state)
        SWEEP: begin
          r_cnt <= r_cnt + AW'(1);
          // clr is deliberately not looked at here: a running sweep is
          // never restarted.
          r_rej <= w_access;
          if (r_cnt == c_LAST_ADDR) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          r_dvalid <= bus.e & bus.r;
          if (bus.clr) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= SWEEP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  ram_core #(
    .DW (DW),
    .AW (AW)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (w_core_we),
    .re    (w_core_re),
    .addr  (w_core_addr),
    .wdata (w_core_wdata),
    .rdata (w_core_rdata)
  );

  assign bus.dout   = w_core_rdata;
  assign bus.dvalid = r_dvalid;
  assign bus.busy   = w_sweeping;
  assign bus.rej    = r_rej;

endmodule : ram_sweep
`default_nettype wire

// File: tb/tb_ram_sweep.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_sweep
// Purpose : Self-checking bench for ram_sweep (DW=16, AW=6, CLR_VAL=A5A5).
//           A behavioural model (array + remaining-sweep counter) is
//           compared with the DUT on every falling edge; directed scenarios
//           add literal expectations, followed by a random phase.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ram_sweep;

  localparam int          DW    = 16;
  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam logic [15:0] CLRV  = 16'hA5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  ram_sweep_if #(.DW(DW), .AW(AW)) bus ();

  ram_sweep #(
    .DW      (DW),
    .AW      (AW),
    .CLR_VAL (CLRV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [DEPTH];
  int          m_left   = DEPTH;   // words still to be cleared (0 = usable)
  logic [15:0] m_dout   = '0;
  logic        m_dvalid = 1'b0;
  logic        m_rej    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   = DEPTH;
      m_dout   = '0;
      m_dvalid = 1'b0;
      m_rej    = 1'b0;
    end else begin
      m_dvalid = 1'b0;
      m_rej    = 1'b0;
      if (m_left > 0) begin
        m_mem[DEPTH - m_left] = CLRV;
        m_left = m_left - 1;
        if (bus.e && (bus.w || bus.r)) m_rej = 1'b1;
      end else begin
        if (bus.e && bus.r) begin
          m_dout   = m_mem[bus.addr];
          m_dvalid = 1'b1;
        end
        if (bus.e && bus.w) m_mem[bus.addr] = bus.din;
        if (bus.clr) m_left = DEPTH;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy",   32'(bus.busy),   32'(m_left > 0));
    chk("dvalid", 32'(bus.dvalid), 32'(m_dvalid));
    chk("rej",    32'(bus.rej),    32'(m_rej));
    chk("dout",   32'(bus.dout),   32'(m_dout));
  end

  // Inputs change just after a falling edge and are held across one rising
  // edge; the task returns on the next falling edge.
  task automatic drive(input logic te, input logic tw, input logic tr,
                       input logic [AW-1:0] ta, input logic [DW-1:0] td,
                       input logic tc);
    bus.e    = te;
    bus.w    = tw;
    bus.r    = tr;
    bus.addr = ta;
    bus.din  = td;
    bus.clr  = tc;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Counts cycles while busy, bounded so a stuck sweep still terminates.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      idle();
      n++;
    end
  endtask

  int          n;
  logic [15:0] held;

  initial begin
    bus.e = 1'b0; bus.w = 1'b0; bus.r = 1'b0;
    bus.addr = '0; bus.din = '0; bus.clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_dout",   32'(bus.dout),   32'h0);
    chk("reset_dvalid", 32'(bus.dvalid), 32'h0);
    chk("reset_busy",   32'(bus.busy),   32'h1);
    chk("reset_rej",    32'(bus.rej),    32'h0);

    // Initial sweep length and cleared contents
    #2 rst = 1'b0;
    @(negedge clk);
    n = 1;
    while (bus.busy && n < 200) begin idle(); n++; end
    chk("init_sweep_len", 32'(n), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b1, AW'(i), '0, 1'b0);
      chk("init_read", 32'(bus.dout), 32'(CLRV));
      chk("init_dvalid", 32'(bus.dvalid), 32'h1);
    end

    // Write i to address i, then back-to-back read-back
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, AW'(i), DW'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b1, AW'(i), '0, 1'b0);
      chk("b2b_dout", 32'(bus.dout), 32'(i));
      chk("b2b_dvalid", 32'(bus.dvalid), 32'h1);
    end
    idle();
    chk("dvalid_drop", 32'(bus.dvalid), 32'h0);

    // Read-before-write
    drive(1'b1, 1'b1, 1'b0, 6'd5, 16'h1234, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 6'd5, 16'hBEEF, 1'b0);
    chk("rbw_old", 32'(bus.dout), 32'h1234);
    drive(1'b1, 1'b0, 1'b1, 6'd5, '0, 1'b0);
    chk("rbw_new", 32'(bus.dout), 32'hBEEF);

    // Disabled accesses do nothing
    held = bus.dout;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, AW'($urandom_range(0, 63)), DW'($urandom), 1'b0);
      chk("e0_dvalid", 32'(bus.dvalid), 32'h0);
      chk("e0_rej",    32'(bus.rej),    32'h0);
      chk("e0_dout",   32'(bus.dout),   32'(held));
    end
    drive(1'b1, 1'b0, 1'b1, 6'd9, '0, 1'b0);
    chk("e0_mem", 32'(bus.dout), 32'd9);

    // clr in IDLE, accesses during the sweep are rejected
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    n = 0;
    drive(1'b1, 1'b1, 1'b0, 6'd3, 16'h7777, 1'b0); n++;
    chk("rej_write", 32'(bus.rej), 32'h1);
    drive(1'b1, 1'b0, 1'b1, 6'd3, '0, 1'b1); n++;   // clr here must not restart
    chk("rej_read", 32'(bus.rej), 32'h1);
    chk("rej_read_dvalid", 32'(bus.dvalid), 32'h0);
    idle(); n++;
    chk("rej_once", 32'(bus.rej), 32'h0);
    while (bus.busy && n < 200) begin idle(); n++; end
    chk("clr_sweep_len", 32'(n), 32'd64);
    drive(1'b1, 1'b0, 1'b1, 6'd3, '0, 1'b0);
    chk("clr_addr3", 32'(bus.dout), 32'(CLRV));

    // Reset mid-sweep at cnt=30
    drive(1'b1, 1'b1, 1'b0, 6'd7, 16'h0707, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 6'd7, '0, 1'b0);
    chk("pre_rst_dout", 32'(bus.dout), 32'h0707);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    repeat (30) idle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_dout",   32'(bus.dout),   32'h0);
    chk("midrst_dvalid", 32'(bus.dvalid), 32'h0);
    chk("midrst_busy",   32'(bus.busy),   32'h1);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n = 1;
    while (bus.busy && n < 200) begin idle(); n++; end
    chk("midrst_sweep_len", 32'(n), 32'd64);
    drive(1'b1, 1'b0, 1'b1, 6'd7, '0, 1'b0);
    chk("midrst_addr7", 32'(bus.dout), 32'(CLRV));

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            AW'($urandom_range(0, 63)), DW'($urandom),
            1'($urandom_range(0, 299) == 0));
    end
    repeat (2) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_sweep
`default_nettype wire
